// File: rtl/usb_reset_sequencer_if.sv
// Lock/attach control bundle between the USB reset sequencer and its environment.
// The slave view is the sequencer itself; the master view drives lock and detach.
interface usb_reset_sequencer_if;
    logic       clk_locked;
    logic       detach;
    logic       core_rst_n;
    logic       pullup_en;
    logic       ready;
    logic [7:0] lock_loss_count;

    modport slave (
        input  clk_locked,
        input  detach,
        output core_rst_n,
        output pullup_en,
        output ready,
        output lock_loss_count
    );

    modport master (
        output clk_locked,
        output detach,
        input  core_rst_n,
        input  pullup_en,
        input  ready,
        input  lock_loss_count
    );
endinterface

// File: rtl/usb_reset_sequencer.sv
// USB bring-up sequencer: qualifies PLL lock, holds the core in reset, then
// enables the D+ pull-up after the attach delay; any lock loss restarts it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | core in reset, waiting for synchronized lock
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// HOLD      | lock qualified, core reset held for RESET_HOLD_CYCLES
// DETACHED  | core running, pull-up off, counting the attach delay
// ATTACHED  | core running, pull-up on, device visible on the bus
module usb_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 4800,
    parameter int RESET_HOLD_CYCLES   = 48,
    parameter int ATTACH_DELAY_CYCLES = 48000
) (
    input logic               clk48mhz,
    input logic               rst_n,
    usb_reset_sequencer_if.slave bus
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                            LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int MAX_P  = (MAX_AB > ATTACH_DELAY_CYCLES) ? MAX_AB : ATTACH_DELAY_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ATTACH_TC = CNT_W'(ATTACH_DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        DETACHED,
        ATTACHED
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_m, lock_s;
    logic             lock_loss;
    logic [7:0]       loss_count;

    // clk_locked comes straight from the PLL and is asynchronous to clk48mhz
    always_ff @(posedge clk48mhz or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.clk_locked;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        lock_loss = 1'b0;
        case (state)
            WAIT_LOCK: if (lock_s) state_nxt = STABLE;
            STABLE: begin
                if (!lock_s)                state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_TC)  state_nxt = HOLD;
            end
            HOLD: begin
                if (!lock_s)                state_nxt = WAIT_LOCK;
                else if (cnt == HOLD_TC)    state_nxt = DETACHED;
            end
            DETACHED: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    lock_loss = 1'b1;
                end else if (bus.detach) begin
                    cnt_nxt   = '0;
                end else if (cnt == ATTACH_TC) begin
                    state_nxt = ATTACHED;
                end
            end
            ATTACHED: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    lock_loss = 1'b1;
                end else if (bus.detach) begin
                    state_nxt = DETACHED;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
        // every state is timed from its own entry
        if (state_nxt != state) cnt_nxt = '0;
    end

    always_ff @(posedge clk48mhz or negedge rst_n) begin
        if (!rst_n)                             loss_count <= 8'd0;
        else if (lock_loss && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end

    assign bus.core_rst_n      = (state == DETACHED) || (state == ATTACHED);
    assign bus.pullup_en       = (state == ATTACHED);
    assign bus.ready           = (state == ATTACHED);
    assign bus.lock_loss_count = loss_count;

endmodule

// File: tb/tb_usb_reset_sequencer.sv
// Randomized and directed bench for usb_reset_sequencer against an
// elapsed-time reference model of the bring-up rules.
module tb_usb_reset_sequencer;

    localparam int LS = 4;
    localparam int RH = 3;
    localparam int AD = 5;

    logic clk48mhz = 1'b0;
    logic rst_n    = 1'b0;

    usb_reset_sequencer_if bus();

    usb_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LS),
        .RESET_HOLD_CYCLES  (RH),
        .ATTACH_DELAY_CYCLES(AD)
    ) dut (
        .clk48mhz(clk48mhz),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk48mhz = ~clk48mhz;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Model: m_t = edges since lock qualification began (-1 = not started),
    // m_q = consecutive detach-free edges since the core came out of reset.
    int m_t, m_q, m_cnt;
    bit m_s1, m_s2;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = -1; m_q = 0; m_cnt = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge();
        bit core_before;
        core_before = (m_t >= LS + RH);
        if (!m_s2) begin
            if (core_before && m_cnt < 255) m_cnt++;
            m_t = -1;
            m_q = 0;
        end else if (m_t < 0) begin
            m_t = 0;
        end else begin
            if (core_before) begin
                if (bus.detach)  m_q = 0;
                else if (m_q < AD) m_q++;
            end
            if (m_t < LS + RH) m_t++;
        end
        m_s2 = m_s1;
        m_s1 = bus.clk_locked;
    endtask

    task automatic step();
        bit exp_core, exp_pull;
        @(posedge clk48mhz);
        if (rst_n) begin
            model_edge();
            edge_n++;
        end
        @(negedge clk48mhz);
        exp_core = (m_t >= LS + RH);
        exp_pull = exp_core && (m_q >= AD);
        chk("core_rst_n", int'(bus.core_rst_n), int'(exp_core));
        chk("pullup_en",  int'(bus.pullup_en),  int'(exp_pull));
        chk("ready",      int'(bus.ready),      int'(exp_pull));
        chk("loss_count", int'(bus.lock_loss_count), m_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        bus.clk_locked = 1'b0;
        bus.detach     = 1'b0;
        run(3);
        chk("rst_core", int'(bus.core_rst_n), 0);

        // basic bring-up: lock sampled at edge 10
        rst_n  = 1'b1;
        edge_n = 0;
        run(9);
        bus.clk_locked = 1'b1;
        run(9);
        chk("bu_core_e18", int'(bus.core_rst_n), 0);
        step();
        chk("bu_core_e19", int'(bus.core_rst_n), 1);
        run(4);
        chk("bu_pull_e23", int'(bus.pullup_en), 0);
        step();
        chk("bu_pull_e24", int'(bus.pullup_en), 1);
        chk("bu_ready_e24", int'(bus.ready), 1);
        chk("bu_count", int'(bus.lock_loss_count), 0);

        // loss while attached
        bus.clk_locked = 1'b0;
        run(2);
        chk("loss_core_k1", int'(bus.core_rst_n), 1);
        step();
        chk("loss_core_k2", int'(bus.core_rst_n), 0);
        chk("loss_pull_k2", int'(bus.pullup_en), 0);
        chk("loss_count1", int'(bus.lock_loss_count), 1);

        // lock flicker during STABLE
        bus.clk_locked = 1'b1;
        run(5);
        bus.clk_locked = 1'b0;
        step();
        bus.clk_locked = 1'b1;
        run(4);
        chk("flick_core", int'(bus.core_rst_n), 0);
        chk("flick_count", int'(bus.lock_loss_count), 1);
        run(20);
        chk("flick_attached", int'(bus.ready), 1);

        // detach for 10 cycles while attached
        bus.detach = 1'b1;
        step();
        chk("det_pull", int'(bus.pullup_en), 0);
        chk("det_core", int'(bus.core_rst_n), 1);
        run(9);
        bus.detach = 1'b0;
        run(4);
        chk("det_pull_4", int'(bus.pullup_en), 0);
        step();
        chk("det_pull_5", int'(bus.pullup_en), 1);

        // lock loss together with detach
        bus.detach     = 1'b1;
        bus.clk_locked = 1'b0;
        run(3);
        chk("detloss_core", int'(bus.core_rst_n), 0);
        chk("detloss_count", int'(bus.lock_loss_count), 2);
        bus.detach     = 1'b0;
        bus.clk_locked = 1'b1;
        run(20);

        // saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            bus.clk_locked = 1'b0;
            run(3);
            bus.clk_locked = 1'b1;
            run(16);
        end
        chk("sat_count", int'(bus.lock_loss_count), 255);

        // asynchronous reset in the middle of HOLD
        bus.clk_locked = 1'b0;
        run(3);
        bus.clk_locked = 1'b1;
        run(7);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_core",  int'(bus.core_rst_n), 0);
        chk("arst_pull",  int'(bus.pullup_en), 0);
        chk("arst_ready", int'(bus.ready), 0);
        chk("arst_count", int'(bus.lock_loss_count), 0);
        @(negedge clk48mhz);
        rst_n = 1'b1;

        // random lock/detach activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) bus.clk_locked = ~bus.clk_locked;
            if ($urandom_range(0, 11) == 0) bus.detach     = ~bus.detach;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
